div_sequencer: RTL and testbench
================================

# div_sequencer

- Multi-cycle integer divide unit with its own sequencing FSM; executes DIV, DIVU, REM, REMU issued by the core's decode stage.
- Sits beside the single-cycle ALU. Decode routes the divide ALU-control codes here instead of to the ALU.
- The `busy` output stalls the pipeline while a divide is in flight.
- Uses a restoring radix-2 algorithm: one quotient bit per cycle, then a sign-fix cycle.

## Interface
Parameters:
- `XLEN`, 32, operand/result width.

Ports (clock and reset first):
- `clk`  in  1  core clock; all state updates on rising edge.
- `rst_n`  in  1  reset; asynchronous and active-low.
- `in_valid`  in  1  divide request present.
- `in_ready`  out  1  unit can accept; equals (state == IDLE).
- `op`  in  6  ALU control code: 101011 DIV, 101100 DIVU, 101101 REM, 101110 REMU.
- `a`  in  XLEN  dividend (rs1).
- `b`  in  XLEN  divisor (rs2).
- `flush`  in  1  kill any in-flight or pending result (branch/jump redirect).
- `out_valid`  out  1  result available.
- `out_ready`  in  1  writeback consumes result.
- `result`  out  XLEN  quotient or remainder.
- `busy`  out  1  (state != IDLE); pipeline stall.

## Operation
- **Accept:** a request is accepted on an edge where `in_valid & in_ready & !flush`. On accept, the unit latches:
  - `op`;
  - sign flags (set for DIV/REM only);
  - |a| and |b|;
  - `neg_q` = sign(a) XOR sign(b);
  - `neg_r` = sign(a).
- **States:**
  - IDLE → CALC on accept (→ DONE under fast path, see Configuration).
  - CALC: 6-bit counter from XLEN-1 down to 0.
  - FIX: sign correction and selection of quotient or remainder.
  - DONE: holds `result` with `out_valid` high until `out_valid & out_ready`, then → IDLE.
- **CALC step (one per cycle):**
  - rem = {rem[XLEN-1:0], dividend[MSB]}; shift dividend left.
  - If rem ≥ {1'b0, divisor}: subtract divisor and shift in quotient bit 1; else shift in 0.
  - The partial remainder is XLEN+1 bits wide.
  - At count 0 → FIX.
- **FIX:**
  - Quotient is negated (two's complement) if `neg_q`.
  - Remainder is negated if `neg_r`.
  - REM/REMU select the remainder; DIV/DIVU select the quotient. → DONE.
- **Special cases:** results must match the RISC-V M spec.
  - Divisor 0: quotient = all-ones, remainder = a.
  - Signed overflow (a = 0x80000000, b = -1 for DIV/REM): quotient = 0x80000000, remainder = 0.
  - Without the macro, both cases fall out of the iterative path plus FIX.
- **Unsupported `op`:** accepted, → DONE with `result` = 0 after 1 cycle, regardless of configuration.
- **Flush:**
  - From any state, forces IDLE on the next edge; `out_valid` drops, the counter clears and no result is produced.
  - `flush` concurrent with `in_valid`: flush wins and nothing is accepted.
- **Back-to-back:** a new accept is possible in the cycle after a DONE handshake (IDLE for ≥1 cycle).

## Timing
- **Reset values:**
  - `in_ready` = 1, `busy` = 0, `out_valid` = 0, `result` = 0.
  - State IDLE, counter 0.
- **Latency:** with accept at edge E, `out_valid` is high after edge E+XLEN+2 (34 for XLEN=32): 32 CALC + 1 FIX + 1 DONE entry.
- **Fast path:** `out_valid` is high after edge E+1.
- **Stable output:** `result` stays stable while `out_valid & !out_ready`.
- **`busy`:** asserted from edge E until the edge where the DONE handshake completes or flush occurs.
- **`rst_n` low mid-operation:** immediately (asynchronously) returns all outputs to their reset values; the in-flight op is discarded.
- **Output timing:** no combinational path from `in_valid` to `out_valid`. `in_ready` depends only on state.

## Configuration
- **`DIV_FAST_SPECIAL_EN` defined:**
  - On accept, divisor-zero and signed-overflow cases skip CALC/FIX and go IDLE → DONE with the spec result.
  - `out_valid` is high 1 cycle after accept.
- **Undefined:** those cases take the full XLEN+2 latency. Results must be identical either way.

## Test plan
- DIVU a=100, b=7 → `result` 14 with `out_valid` 34 cycles after accept; REMU same operands → 2.
- DIV a=-7 (0xFFFFFFF9), b=2 → 0xFFFFFFFD; REM → 0xFFFFFFFF; DIV a=7, b=-2 → 0xFFFFFFFD.
- DIV a=5, b=0 → 0xFFFFFFFF; REM → 5; DIV a=0x80000000, b=0xFFFFFFFF → 0x80000000, REM → 0. Latency is 1 cycle with `DIV_FAST_SPECIAL_EN`, 34 without.
- Backpressure: hold `out_ready`=0 for 5 cycles after `out_valid` → `result` stable, `busy`=1, `in_ready`=0. Release → IDLE next edge; a second op is accepted the following cycle.
- Flush at cycle 10 of CALC → IDLE next edge, no `out_valid`. Flush with concurrent `in_valid` → no accept.
- Assert `rst_n` low at cycle 20 of CALC → all outputs at reset values immediately. A following DIVU 9/3 → 3.

Source files
------------

// File: rtl/div_sequencer_if.sv
// div_sequencer_if: request/response bundle between the decode/writeback
// stages and the multi-cycle divide unit. The core side is the master; the
// divide unit is the slave.
interface div_sequencer_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [5:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            busy;

  modport master (
    output in_valid, op, a, b, flush, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  in_valid, op, a, b, flush, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface

// File: rtl/div_sequencer.sv
// div_sequencer: multi-cycle restoring radix-2 divider for DIV/DIVU/REM/REMU.
// One quotient bit per CALC cycle, then a FIX cycle for sign correction and
// quotient/remainder selection. The result is held in DONE until writeback
// takes it; busy stalls the pipeline for the whole time the unit is not IDLE.
//
// Optional build macro DIV_FAST_SPECIAL_EN: divide-by-zero and signed
// overflow bypass the iterative path and reach DONE straight from IDLE.
// Results are identical with or without the macro; only latency differs.
module div_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  div_sequencer_if.slave  bus
);

  localparam logic [5:0] OP_DIV  = 6'b101011;
  localparam logic [5:0] OP_DIVU = 6'b101100;
  localparam logic [5:0] OP_REM  = 6'b101101;
  localparam logic [5:0] OP_REMU = 6'b101110;

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  state_t          state_q, state_d;
  logic [5:0]      cnt_q;
  logic [XLEN:0]   rem_q;       // partial remainder, one bit wider than XLEN
  logic [XLEN-1:0] quo_q;       // dividend shifts out the top, quotient in the bottom
  logic [XLEN-1:0] dvs_q;       // |divisor|
  logic            is_rem_q;
  logic            neg_q_q;
  logic            neg_r_q;
  logic            dvs_zero_q;
  logic [XLEN-1:0] result_q;
  logic            out_valid_q;

  // ---------------------------------------------------------------------
  // Request decode (only meaningful while IDLE)
  // ---------------------------------------------------------------------
  logic            op_signed, op_rem, op_known;
  logic            a_neg, b_neg, b_zero, s_ovf, fast_hit, accept, handshake;
  logic [XLEN-1:0] a_abs, b_abs, fast_result;

  assign op_signed = (bus.op == OP_DIV) || (bus.op == OP_REM);
  assign op_rem    = (bus.op == OP_REM) || (bus.op == OP_REMU);
  assign op_known  = (bus.op == OP_DIV) || (bus.op == OP_DIVU) ||
                     (bus.op == OP_REM) || (bus.op == OP_REMU);

  assign a_neg  = op_signed & bus.a[XLEN-1];
  assign b_neg  = op_signed & bus.b[XLEN-1];
  assign a_abs  = a_neg ? (~bus.a + 1'b1) : bus.a;
  assign b_abs  = b_neg ? (~bus.b + 1'b1) : bus.b;
  assign b_zero = (bus.b == '0);
  assign s_ovf  = op_signed & (bus.a == INT_MIN) & (bus.b == '1);

`ifdef DIV_FAST_SPECIAL_EN
  assign fast_hit = b_zero | s_ovf;
`else
  assign fast_hit = 1'b0;
`endif

  // Divide-by-zero: q = all ones, r = a. Signed overflow: q = INT_MIN, r = 0.
  assign fast_result = b_zero ? (op_rem ? bus.a : '1)
                              : (op_rem ? '0    : INT_MIN);

  assign accept    = bus.in_valid & (state_q == IDLE) & ~bus.flush;
  assign handshake = out_valid_q & bus.out_ready;

  // ---------------------------------------------------------------------
  // Iteration step and sign fix
  // ---------------------------------------------------------------------
  logic [XLEN:0]   rem_shift, rem_step;
  logic            rem_ge;
  logic [XLEN-1:0] quo_step, q_fix, r_fix, fix_result;

  assign rem_shift = {rem_q[XLEN-1:0], quo_q[XLEN-1]};
  assign rem_ge    = (rem_shift >= {1'b0, dvs_q});
  assign rem_step  = rem_ge ? (rem_shift - {1'b0, dvs_q}) : rem_shift;
  assign quo_step  = {quo_q[XLEN-2:0], rem_ge};

  // A zero divisor yields all-ones magnitude; leaving it un-negated keeps
  // the quotient at -1 for negative dividends too, as RISC-V requires.
  assign q_fix      = (neg_q_q & ~dvs_zero_q) ? (~quo_q + 1'b1) : quo_q;
  assign r_fix      = neg_r_q ? (~rem_q[XLEN-1:0] + 1'b1) : rem_q[XLEN-1:0];
  assign fix_result = is_rem_q ? r_fix : q_fix;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; flush overrides everything.
  // NOTE: state_d gets a default before any branch so no latch is inferred.
  always_comb begin
    state_d = state_q;
    if (bus.flush) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: if (accept) state_d = (!op_known || fast_hit) ? DONE : CALC;
        CALC: if (cnt_q == '0) state_d = FIX;
        FIX:  state_d = DONE;
        DONE: if (handshake) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Datapath: operand capture, iteration, result and valid registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      is_rem_q    <= 1'b0;
      neg_q_q     <= 1'b0;
      neg_r_q     <= 1'b0;
      dvs_zero_q  <= 1'b0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
    end else if (bus.flush) begin
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          out_valid_q <= 1'b0;
          if (accept) begin
            cnt_q      <= 6'(XLEN - 1);
            rem_q      <= '0;
            quo_q      <= a_abs;
            dvs_q      <= b_abs;
            is_rem_q   <= op_rem;
            neg_q_q    <= a_neg ^ b_neg;
            neg_r_q    <= a_neg;
            dvs_zero_q <= b_zero;
            if (!op_known)    result_q <= '0;
            else if (fast_hit) result_q <= fast_result;
          end
        end
        CALC: begin
          rem_q <= rem_step;
          quo_q <= quo_step;
          if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
        end
        FIX: begin
          result_q <= fix_result;
        end
        DONE: begin
          // Valid rises on the cycle after DONE entry and falls on handshake.
          out_valid_q <= ~handshake;
        end
        default: out_valid_q <= 1'b0;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;

endmodule

// File: tb/tb_div_sequencer.sv
// tb_div_sequencer: directed plus randomized checks of div_sequencer against
// an arithmetic reference model of the RISC-V M divide rules.
module tb_div_sequencer;

  localparam int XLEN = 32;
  localparam logic [5:0] OP_DIV  = 6'b101011;
  localparam logic [5:0] OP_DIVU = 6'b101100;
  localparam logic [5:0] OP_REM  = 6'b101101;
  localparam logic [5:0] OP_REMU = 6'b101110;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  div_sequencer_if #(.XLEN(XLEN)) bus ();

  div_sequencer #(.XLEN(XLEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [XLEN-1:0] obs,
                       input logic [XLEN-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: RISC-V M results from plain signed/unsigned arithmetic.
  function automatic logic [31:0] model(input logic [5:0] op,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    int signed sa, sb;
    logic ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      OP_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      OP_REMU: return (b == 0) ? a : a % b;
      OP_DIV:  return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa / sb);
      OP_REM:  return (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
      default: return 32'h0;
    endcase
  endfunction

  function automatic int exp_lat(input logic [5:0] op, input logic [31:0] a,
                                 input logic [31:0] b);
    logic known, signed_op;
    known     = (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
    signed_op = (op == OP_DIV) || (op == OP_REM);
    if (!known) return 1;
`ifdef DIV_FAST_SPECIAL_EN
    if (b == 0) return 1;
    if (signed_op && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`endif
    return XLEN + 2;
  endfunction

  // Issue one op (accepted on the next edge), wait for the result, check
  // latency and value, hold out_ready low for 'hold' cycles, then consume.
  task automatic run_op(input string tag, input logic [5:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input int hold);
    int lat;
    bus.op       = op;
    bus.a        = a;
    bus.b        = b;
    bus.in_valid = 1'b1;
    check({tag, "_in_ready"}, bus.in_ready, 1'b1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check({tag, "_busy"}, bus.busy, 1'b1);
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"}, lat, exp_lat(op, a, b));
    check({tag, "_res"}, bus.result, exp_res);
    repeat (hold) begin
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check({tag, "_idle"}, bus.busy, 1'b0);
  endtask

  // Watch for a spurious out_valid over n cycles.
  task automatic expect_quiet(input string tag, input int n);
    logic seen;
    seen = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
      if (bus.out_valid === 1'b1) seen = 1'b1;
    end
    check(tag, seen, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] held;
    logic [5:0]  ops[4];
    logic [5:0]  rop;
    logic [31:0] ra, rb;

    ops = '{OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    bus.in_valid  = 1'b0;
    bus.op        = '0;
    bus.a         = '0;
    bus.b         = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;

    // Reset values while rst_n is held low.
    #12;
    check("rst_in_ready", bus.in_ready, 1'b1);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_result", bus.result, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases with literal expectations.
    run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14, 0);
    run_op("remu_100_7", OP_REMU, 32'd100, 32'd7, 32'd2, 0);
    run_op("div_m7_2",   OP_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0);
    run_op("rem_m7_2",   OP_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0);
    run_op("div_7_m2",   OP_DIV,  32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 0);
    run_op("div_5_0",    OP_DIV,  32'd5, 32'd0, 32'hFFFF_FFFF, 0);
    run_op("rem_5_0",    OP_REM,  32'd5, 32'd0, 32'd5, 0);
    run_op("div_m5_0",   OP_DIV,  32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 0);
    run_op("divu_5_0",   OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 0);
    run_op("div_ovf",    OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
    run_op("rem_ovf",    OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 0);
    run_op("bad_op",     6'b000001, 32'd100, 32'd7, 32'h0, 0);

    // Backpressure: result, busy and in_ready held while out_ready is low.
    bus.op = OP_DIVU; bus.a = 32'd1000; bus.b = 32'd9; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (XLEN + 2) begin
      @(posedge clk); #1;
    end
    check("bp_valid", bus.out_valid, 1'b1);
    held = bus.result;
    check("bp_res", held, 32'd111);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_stable", bus.result, held);
      check("bp_busy", bus.busy, 1'b1);
      check("bp_in_ready", bus.in_ready, 1'b0);
      check("bp_still_valid", bus.out_valid, 1'b1);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("bp_release_idle", bus.in_ready, 1'b1);
    check("bp_release_valid", bus.out_valid, 1'b0);
    run_op("b2b_divu", OP_DIVU, 32'd81, 32'd9, 32'd9, 0);

    // Flush ten cycles into CALC.
    bus.op = OP_DIV; bus.a = 32'd12345; bus.b = 32'd5; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (9) begin
      @(posedge clk); #1;
    end
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    check("flush_busy", bus.busy, 1'b0);
    check("flush_in_ready", bus.in_ready, 1'b1);
    expect_quiet("flush_no_valid", 40);

    // Flush concurrent with in_valid: nothing is accepted.
    bus.op = OP_DIVU; bus.a = 32'd50; bus.b = 32'd5;
    bus.in_valid = 1'b1; bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.flush = 1'b0;
    check("flush_acc_busy", bus.busy, 1'b0);
    expect_quiet("flush_acc_no_valid", 40);

    // Asynchronous reset twenty cycles into CALC.
    bus.op = OP_DIVU; bus.a = 32'hDEAD_BEEF; bus.b = 32'd3; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
    end
    #1 rst_n = 1'b0;
    #1;
    check("arst_in_ready", bus.in_ready, 1'b1);
    check("arst_busy", bus.busy, 1'b0);
    check("arst_out_valid", bus.out_valid, 1'b0);
    check("arst_result", bus.result, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op("post_rst_divu", OP_DIVU, 32'd9, 32'd3, 32'd3, 0);

    // Randomized operands against the reference model.
    for (int n = 0; n < 40; n++) begin
      rop = ops[$urandom_range(0, 3)];
      ra  = $urandom;
      if ($urandom_range(0, 5) == 0) ra = 32'h8000_0000;
      case ($urandom_range(0, 7))
        0:       rb = 32'h0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = 32'($urandom_range(1, 15));
        3:       rb = ra >> $urandom_range(0, 31);
        default: rb = $urandom;
      endcase
      run_op($sformatf("rnd%0d_op%h", n, rop), rop, ra, rb, model(rop, ra, rb),
             $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
